// File: rtl/tff_mod_counter_if.sv
// Bus bundle for the modulo-N toggle-flip-flop counter. It groups the control
// inputs and the count/flag outputs.
//
// Handshake: this bundle has no valid/ready pair. The counter samples every
// control input on each rising clk edge. The master must hold en/up_dn/load/
// load_val stable around that edge. q and div_out are registered. tc is
// combinational from the registered q and the current en/load/up_dn.
interface tff_mod_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             div_out;

  modport master (
    output en, up_dn, load, load_val,
    input  q, tc, div_out
  );

  modport slave (
    input  en, up_dn, load, load_val,
    output q, tc, div_out
  );
endinterface

// File: rtl/tff_mod_counter.sv
// Loadable modulo-MODULUS up/down counter built from a bank of T flip-flops.
// Each bit's T input comes from the lower bits and the direction. At the wrap
// point the T vector is overridden to land on 0 (up) or MODULUS-1 (down).
// A terminal-count flag and a divide-by-2*MODULUS square wave are produced
// alongside the count.
module tff_mod_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  tff_mod_counter_if.slave  bus
);

  // Last legal count value, and the modulus widened by one bit.
  // The widening lets MODULUS == 2**WIDTH be compared against load_val.
  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_W = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] q_q, q_d;
  logic             div_q, div_d;
  logic [WIDTH-1:0] t_vec;
  logic [WIDTH-1:0] load_clamped;
  logic             at_max, at_zero;
  logic             tc;

  assign at_max  = (q_q == MAX_Q);
  assign at_zero = (q_q == '0);

  // Terminal count: the next enabled edge is a wrap in the current direction.
  assign tc = bus.en & ~bus.load & (bus.up_dn ? at_max : at_zero);

  // Out-of-range load values saturate to the last legal count.
  assign load_clamped = ({1'b0, bus.load_val} < MOD_W) ? bus.load_val : MAX_Q;

  // Per-bit toggle enables. A bit flips when all lower bits are 1 (up) or all
  // lower bits are 0 (down). At the wrap, T is overridden to reach the target.
  always_comb begin
    logic run_and;
    logic run_nor;
    t_vec   = '0;
    run_and = 1'b1;
    run_nor = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      t_vec[i] = bus.up_dn ? run_and : run_nor;
      run_and  = run_and & q_q[i];
      run_nor  = run_nor & ~q_q[i];
    end
    if (bus.up_dn && at_max) begin
      t_vec = q_q;
    end else if (!bus.up_dn && at_zero) begin
      t_vec = q_q ^ MAX_Q;
    end
  end

  // Next-state selection: load beats count, count beats hold.
  always_comb begin
    q_d   = q_q;
    div_d = div_q ^ tc;
    if (bus.load) begin
      q_d = load_clamped;
    end else if (bus.en) begin
      q_d = q_q ^ t_vec;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q   <= '0;
      div_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      div_q <= div_d;
    end
  end

  assign bus.q       = q_q;
  assign bus.tc      = tc;
  assign bus.div_out = div_q;

endmodule

// File: tb/tb_tff_mod_counter.sv
// Bench for tff_mod_counter. There are two instances: the default MODULUS=10
// on 4 bits, and the full-range case MODULUS=8 on 3 bits. Each one is
// compared against an arithmetic reference model on every clock.
module tb_tff_mod_counter;

  localparam int MOD_A = 10;
  localparam int MOD_B = 8;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  // Reference model state.
  int   ma_q, ma_div, mb_q, mb_div;
  logic m_valid;

  tff_mod_counter_if #(.WIDTH(4)) if_a ();
  tff_mod_counter_if #(.WIDTH(3)) if_b ();

  tff_mod_counter #(.WIDTH(4), .MODULUS(MOD_A)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_a.slave)
  );

  tff_mod_counter #(.WIDTH(3), .MODULUS(MOD_B)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_b.slave)
  );

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int model_tc(input int q, input int m, input logic en,
                                  input logic ld, input logic up);
    return (en && !ld && (up ? (q == m - 1) : (q == 0))) ? 1 : 0;
  endfunction

  function automatic int model_next(input int q, input int m, input logic en,
                                    input logic ld, input logic up, input int lv);
    if (ld) return (lv < m) ? lv : m - 1;
    if (en) return up ? (q + 1) % m : (q + m - 1) % m;
    return q;
  endfunction

  // Run one clock. Drive the inputs, check tc before the edge, then check
  // the registered outputs just after the edge.
  task automatic cycle(input logic rst, input logic en, input logic up,
                       input logic ld, input int lv);
    int tca, tcb;
    rst_n         = rst;
    if_a.en       = en;   if_b.en       = en;
    if_a.up_dn    = up;   if_b.up_dn    = up;
    if_a.load     = ld;   if_b.load     = ld;
    if_a.load_val = 4'(lv);
    if_b.load_val = 3'(lv);
    #1;
    tca = model_tc(ma_q, MOD_A, en, ld, up);
    tcb = model_tc(mb_q, MOD_B, en, ld, up);
    if (m_valid) begin
      chk("tc_a", 32'(if_a.tc), 32'(tca));
      chk("tc_b", 32'(if_b.tc), 32'(tcb));
    end
    @(posedge clk);
    if (!rst) begin
      ma_q = 0; ma_div = 0; mb_q = 0; mb_div = 0;
      m_valid = 1'b1;
    end else begin
      if (tca != 0) ma_div ^= 1;
      if (tcb != 0) mb_div ^= 1;
      ma_q = model_next(ma_q, MOD_A, en, ld, up, lv % 16);
      mb_q = model_next(mb_q, MOD_B, en, ld, up, lv % 8);
    end
    #1;
    if (m_valid) begin
      chk("q_a",   32'(if_a.q),       32'(ma_q));
      chk("div_a", 32'(if_a.div_out), 32'(ma_div));
      chk("q_b",   32'(if_b.q),       32'(mb_q));
      chk("div_b", 32'(if_b.div_out), 32'(mb_div));
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    m_valid  = 1'b0;
    ma_q = 0; ma_div = 0; mb_q = 0; mb_div = 0;
    rst_n = 1'b0;
    if_a.en = 1'b0; if_a.up_dn = 1'b1; if_a.load = 1'b0; if_a.load_val = '0;
    if_b.en = 1'b0; if_b.up_dn = 1'b1; if_b.load = 1'b0; if_b.load_val = '0;

    // 1. Reset for two clocks with en=1, then count up 1..9.
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 0);
    chk("rst_q",   32'(if_a.q), 32'd0);
    chk("rst_div", 32'(if_a.div_out), 32'd0);
    chk("rst_tc",  32'(if_a.tc), 32'd0);
    for (int i = 0; i < 9; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0, 0);
    chk("up_q9", 32'(if_a.q), 32'd9);
    chk("up_tc9", 32'(if_a.tc), 32'd1);

    // 2. Wrap to 0 toggles div_out; after 20 enabled edges it is back to 0.
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 0);
    chk("wrap_q0", 32'(if_a.q), 32'd0);
    chk("wrap_div1", 32'(if_a.div_out), 32'd1);
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0, 0);
    chk("div_back0", 32'(if_a.div_out), 32'd0);

    // 3. Count down from 0: wrap to 9, then 8, 7.
    if_a.up_dn = 1'b0;
    #1;
    chk("dn_tc0", 32'(if_a.tc), 32'd1);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 0);
    chk("dn_wrap_q9", 32'(if_a.q), 32'd9);
    chk("dn_wrap_div", 32'(if_a.div_out), 32'd1);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 0);
    chk("dn_q7", 32'(if_a.q), 32'd7);

    // 4. Loads: an in-range value, then an out-of-range value that clamps.
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 4);
    chk("load4", 32'(if_a.q), 32'd4);
    chk("load_div", 32'(if_a.div_out), 32'd1);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 13);
    chk("load13_clamp", 32'(if_a.q), 32'd9);

    // 5. Hold at 6 for five clocks, then hold at 9 with no wrap.
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 6);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b1, 1'b0, 0);
    chk("hold6", 32'(if_a.q), 32'd6);
    chk("hold6_tc", 32'(if_a.tc), 32'd0);
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 9);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 0);
    chk("hold9_q", 32'(if_a.q), 32'd9);
    chk("hold9_tc", 32'(if_a.tc), 32'd0);

    // 6. Reset wins over load at the same edge; a reset pulse between edges does nothing.
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 7);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 3);
    chk("rst_over_load_q", 32'(if_a.q), 32'd0);
    chk("rst_over_load_div", 32'(if_a.div_out), 32'd0);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 5);
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    chk("glitch_rst_q", 32'(if_a.q), 32'd5);

    // Randomized traffic on both instances.
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 59) != 0),
            ($urandom_range(0, 9) < 8),
            1'($urandom),
            ($urandom_range(0, 9) == 0),
            int'($urandom_range(0, 15)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
